// File: rtl/dff_chk_pkg.sv
// Shared types and constants for the dual-reset flop response checker.
package dff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SAMPLES_DEF = 150;
  localparam int CNT_W_DEF   = 16;

  // Sliced down to CNT_W in the checker; marks "no mismatch seen yet".
  localparam logic [31:0] IDX_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/dff_reset_checker_if.sv
// Stimulus/response bundle between the flop-under-test side and the checker.
interface dff_reset_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             mon_d;
  logic             mon_sync_reset;
  logic             mon_async_reset;
  logic             mon_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [CNT_W-1:0] sample_idx;

  modport master (
    output start, mon_d, mon_sync_reset, mon_async_reset, mon_q,
    input  busy, done, pass, err_count, first_err_idx, sample_idx
  );

  modport slave (
    input  start, mon_d, mon_sync_reset, mon_async_reset, mon_q,
    output busy, done, pass, err_count, first_err_idx, sample_idx
  );
endinterface

// File: rtl/dff_reset_checker_ref_model.sv
// Cycle-accurate reference for the dual-reset flop plus per-edge compare.
module dff_ref_model (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  input  logic sync_reset,
  input  logic async_reset,
  input  logic q,
  output logic mismatch
);

  logic exp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= 1'b0;
    end else if (en) begin
      exp_q <= (async_reset | sync_reset) ? 1'b0 : d;
    end
  end

  // A live async reset clears the flop immediately, so expect 0 regardless of exp_q.
  assign mismatch = q != (async_reset ? 1'b0 : exp_q);

endmodule

// File: rtl/dff_reset_checker.sv
// Response checker for the dual-reset flop: run sequencing, error counting, verdict.
//  state | meaning
//  IDLE  | waiting for start
//  PRIME | one cycle to load the reference model, no compare
//  RUN   | compare one sample per edge, SAMPLES edges total
//  DONE  | results held, start begins a new run
module dff_reset_checker
  import dff_chk_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  dff_reset_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] IDX_ALL  = IDX_NONE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

  state_t           state;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [CNT_W-1:0] err_r;
  logic [CNT_W-1:0] first_r;
  logic [CNT_W-1:0] idx_r;
  logic             model_en;
  logic             mismatch;

  assign model_en = (state == PRIME) || (state == RUN);

  dff_ref_model u_ref (
    .clk         (clk),
    .reset       (reset),
    .en          (model_en),
    .d           (bus.mon_d),
    .sync_reset  (bus.mon_sync_reset),
    .async_reset (bus.mon_async_reset),
    .q           (bus.mon_q),
    .mismatch    (mismatch)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      err_r   <= '0;
      first_r <= IDX_ALL;
      idx_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Counters clear on entry so PRIME already shows a fresh run.
          if (bus.start) begin
            state   <= PRIME;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= '0;
            first_r <= IDX_ALL;
            idx_r   <= '0;
          end
        end
        PRIME: begin
          state <= RUN;
        end
        RUN: begin
          if (mismatch) begin
            if (err_r != IDX_ALL) err_r <= err_r + 1'b1;
            if (first_r == IDX_ALL) first_r <= idx_r;
          end
          if (idx_r == LAST_IDX) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            // Fold in the final compare, which err_r has not seen yet.
            pass_r <= (err_r == '0) && !mismatch;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.pass          = pass_r;
  assign bus.err_count     = err_r;
  assign bus.first_err_idx = first_r;
  assign bus.sample_idx    = idx_r;

endmodule

// File: tb/tb_dff_reset_checker.sv
// Directed bench: behavioural flop (ideal or faulty) feeding the checker, scenario table plus corner sequences.
module tb_dff_reset_checker;
  import dff_chk_pkg::*;

  localparam logic [31:0] NONE16 = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  dff_reset_checker_if #(.CNT_W(16)) bus ();
  dff_reset_checker_if #(.CNT_W(2))  bus_s ();

  dff_reset_checker #(.SAMPLES(150), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dff_reset_checker #(.SAMPLES(3), .CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  logic start_s, stim_d, stim_sr, stim_ar;
  int   fmode;
  logic q_ideal, q_nosync, q_syncasync, q_pick;

  // Flop under test variants: 0 ideal, 1 ignores sync reset, 2 async made synchronous, 3 inverted q.
  always @(posedge clk or posedge stim_ar)
    if (stim_ar) q_ideal <= 1'b0;
    else if (stim_sr) q_ideal <= 1'b0;
    else q_ideal <= stim_d;

  always @(posedge clk or posedge stim_ar)
    if (stim_ar) q_nosync <= 1'b0;
    else q_nosync <= stim_d;

  always @(posedge clk)
    q_syncasync <= (stim_ar | stim_sr) ? 1'b0 : stim_d;

  always_comb begin
    q_pick = q_ideal;
    case (fmode)
      1: q_pick = q_nosync;
      2: q_pick = q_syncasync;
      3: q_pick = ~q_ideal;
      default: q_pick = q_ideal;
    endcase
  end

  assign bus.start             = start_s;
  assign bus.mon_d             = stim_d;
  assign bus.mon_sync_reset    = stim_sr;
  assign bus.mon_async_reset   = stim_ar;
  assign bus.mon_q             = q_pick;
  assign bus_s.start           = start_s;
  assign bus_s.mon_d           = stim_d;
  assign bus_s.mon_sync_reset  = stim_sr;
  assign bus_s.mon_async_reset = stim_ar;
  assign bus_s.mon_q           = q_pick;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stimulus for cycle j of a run (j = 0 is the cycle carrying start).
  task automatic drive_stim(input int pat, input int j);
    case (pat)
      0: begin
        stim_ar = (j < 10);
        stim_d  = (((j * 20) / 23) % 2) == 1;
        stim_sr = ((j * 20) % 113) < 20;
      end
      1: begin
        stim_ar = 1'b0;
        stim_d  = 1'b1;
        stim_sr = (j == 20) || (j == 21) || (j == 50) || (j == 80) || (j == 81) || (j == 130);
      end
      2: begin
        stim_ar = (j == 60);
        stim_d  = 1'b1;
        stim_sr = 1'b0;
      end
      default: begin
        stim_ar = 1'b0;
        stim_d  = 1'b1;
        stim_sr = (j == 5) || (j == 10) || (j == 15);
      end
    endcase
  endtask

  task automatic run_scenario(input int mode, input int pat, input int glitch, input int rst_at,
                              output int cycles);
    bit glitched;
    bit pending;
    glitched = 1'b0;
    pending  = 1'b0;
    fmode    = mode;
    drive_stim(pat, 0);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cycles  = 0;
    for (int j = 1; j <= 200 && !bus.done; j++) begin
      if (rst_at >= 0 && bus.busy && int'(bus.sample_idx) == rst_at) begin
        check("pre_reset_err", 32'(bus.err_count), 3);
        reset = 1'b1;
        drive_stim(pat, j);
        tick();
        reset = 1'b0;
        return;
      end
      if (glitch >= 0 && !glitched && bus.busy && int'(bus.sample_idx) == glitch) begin
        start_s  = 1'b1;
        glitched = 1'b1;
        pending  = 1'b1;
      end
      drive_stim(pat, j);
      tick();
      start_s = 1'b0;
      cycles++;
      if (pending) begin
        check("glitch_idx", 32'(bus.sample_idx), 32'(glitch + 1));
        check("glitch_busy", 32'(bus.busy), 1);
        pending = 1'b0;
      end
    end
    check("run_done", 32'(bus.done), 1);
  endtask

  typedef struct {
    int          mode;
    int          pat;
    int          glitch;
    logic [31:0] exp_err;
    logic [31:0] exp_first;
    logic        exp_pass;
    logic [31:0] exp_small_err;
  } vec_t;

  vec_t tbl[5];
  int   cyc;

  initial begin
    tbl[0] = '{mode: 0, pat: 0, glitch: -1, exp_err: 0,   exp_first: NONE16, exp_pass: 1'b1, exp_small_err: 0};
    tbl[1] = '{mode: 1, pat: 1, glitch: -1, exp_err: 6,   exp_first: 19,     exp_pass: 1'b0, exp_small_err: 0};
    tbl[2] = '{mode: 2, pat: 2, glitch: -1, exp_err: 1,   exp_first: 58,     exp_pass: 1'b0, exp_small_err: 0};
    tbl[3] = '{mode: 0, pat: 0, glitch: 20, exp_err: 0,   exp_first: NONE16, exp_pass: 1'b1, exp_small_err: 0};
    tbl[4] = '{mode: 3, pat: 0, glitch: -1, exp_err: 150, exp_first: 0,      exp_pass: 1'b0, exp_small_err: 3};

    reset   = 1'b1;
    start_s = 1'b0;
    stim_d  = 1'b0;
    stim_sr = 1'b0;
    stim_ar = 1'b1;
    fmode   = 0;
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_pass",  32'(bus.pass), 0);
    check("rst_err",   32'(bus.err_count), 0);
    check("rst_first", 32'(bus.first_err_idx), NONE16);
    check("rst_idx",   32'(bus.sample_idx), 0);
    check("rst_small_first", 32'(bus_s.first_err_idx), 3);

    for (int i = 0; i < 5; i++) begin
      run_scenario(tbl[i].mode, tbl[i].pat, tbl[i].glitch, -1, cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 151);
      check($sformatf("v%0d_err", i),    32'(bus.err_count), tbl[i].exp_err);
      check($sformatf("v%0d_first", i),  32'(bus.first_err_idx), tbl[i].exp_first);
      check($sformatf("v%0d_pass", i),   32'(bus.pass), 32'(tbl[i].exp_pass));
      check($sformatf("v%0d_busy", i),   32'(bus.busy), 0);
      check($sformatf("v%0d_small_done", i), 32'(bus_s.done), 1);
      check($sformatf("v%0d_small_err", i),  32'(bus_s.err_count), tbl[i].exp_small_err);
      check($sformatf("v%0d_small_pass", i), 32'(bus_s.pass), 32'(tbl[i].exp_small_err == 0));
    end

    // Start while DONE with 150 errors held: PRIME next cycle with cleared counters.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check("redo_busy",  32'(bus.busy), 1);
    check("redo_done",  32'(bus.done), 0);
    check("redo_pass",  32'(bus.pass), 0);
    check("redo_err",   32'(bus.err_count), 0);
    check("redo_first", 32'(bus.first_err_idx), NONE16);
    check("redo_idx",   32'(bus.sample_idx), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset mid-run after three mismatches, then a fresh clean run.
    run_scenario(1, 3, -1, 40, cyc);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_done",  32'(bus.done), 0);
    check("mid_rst_err",   32'(bus.err_count), 0);
    check("mid_rst_first", 32'(bus.first_err_idx), NONE16);
    check("mid_rst_idx",   32'(bus.sample_idx), 0);
    tick();
    check("mid_rst_idle", 32'(bus.busy), 0);
    run_scenario(0, 0, -1, -1, cyc);
    check("clean_cycles", 32'(cyc), 151);
    check("clean_err",    32'(bus.err_count), 0);
    check("clean_first",  32'(bus.first_err_idx), NONE16);
    check("clean_pass",   32'(bus.pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_reset_checker.md
# dff_reset_checker

Synthesizable response checker for the dual-reset D flip-flop (async + sync reset). Sits beside the flop under test on the same clock, samples its stimulus (d, sync_reset, async_reset) and output q every rising edge, runs a cycle-accurate reference model, and reports mismatch count, first failing sample, and a pass/fail verdict at the end of a fixed-length window. It is the checking end of the flop's stimulus interface, so benches and on-chip self-test both use one verdict source.

## Interface
- SAMPLES, 150, compared samples per run (3000 ns at a 20 ns clock period).
- CNT_W, 16, width of counters and indices; must satisfy 2^CNT_W > SAMPLES.

- clk  in  1  rising-edge clock, shared with the flop under test.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  one-cycle pulse that begins a run; honoured in IDLE and DONE only.
- mon_d  in  1  d input of the flop under test.
- mon_sync_reset  in  1  sync_reset of the flop under test.
- mon_async_reset  in  1  async_reset of the flop under test.
- mon_q  in  1  q output of the flop under test.
- busy  out  1  high in PRIME and RUN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count == 0.
- err_count  out  CNT_W  mismatches this run; saturates at all-ones.
- first_err_idx  out  CNT_W  sample_idx of first mismatch; all-ones if none.
- sample_idx  out  CNT_W  index of the sample being compared.

## Operation
- Reference model: exp_q <= (mon_async_reset | mon_sync_reset) ? 0 : mon_d, updated every edge in PRIME and RUN.
- Compare rule at each RUN edge: if mon_async_reset == 1, expected = 0 (async clear already visible); else expected = exp_q. Mismatch when mon_q != expected.
- Async pulse that both asserts and releases between two edges is not detectable; out of scope.
- Async released mid-cycle: exp_q is 0 from the prior edge, q stays 0 until the next edge; consistent with the rule, no special case.
- FSM states IDLE, PRIME, RUN, DONE:
  - IDLE: start -> PRIME.
  - PRIME: exactly one cycle; loads exp_q, clears err_count, sample_idx = 0, first_err_idx = all-ones; -> RUN. No compare.
  - RUN: compare, update counters, sample_idx++; at sample_idx == SAMPLES-1, compare then -> DONE.
  - DONE: outputs held; start -> PRIME (new run).
- start in PRIME/RUN ignored. reset in any state -> IDLE.
- first_err_idx written only when still all-ones and a mismatch occurs.
- err_count increments unless already all-ones.

## Timing
- Reset values: busy 0, done 0, pass 0, err_count 0, first_err_idx all-ones, sample_idx 0, state IDLE, exp_q 0.
- start at edge N -> PRIME during cycle N+1 -> first compare at edge N+2.
- Run length: 1 PRIME + SAMPLES RUN cycles; done rises the cycle after the last compare.
- Counter outputs are registered; they reflect the compare of the previous edge.
- Reset mid-RUN: all outputs return to reset values next cycle; partial results discarded.
- Mismatch on the final sample is counted before done rises.

## Structure
- Package dff_chk_pkg: state enum (IDLE, PRIME, RUN, DONE), default CNT_W, all-ones constant for first_err_idx.
- Sub-module dff_ref_model: exp_q register plus compare logic, outputs mismatch. Top holds the FSM and counters.

## Test plan
- Ideal flop model wired in, mon_async_reset = 1 for 200 ns then released, d toggling every 23 ns, sync_reset every 113 ns -> done after 151 cycles post-start, err_count 0, pass 1, first_err_idx all-ones.
- Faulty model ignoring sync_reset, with 6 sync_reset-high cycles where d = 1 -> err_count 6, first_err_idx = index of first such cycle, pass 0.
- Faulty model with async reset made synchronous, async asserted mid-cycle while q = 1 -> exactly one mismatch at that edge.
- reset pulsed at sample_idx 40 of a run with 3 errors -> IDLE, err_count 0, done 0; new start gives a full clean 150-sample run.
- mon_q forced inverted for the whole run -> err_count 150 (excluding cycles where inversion matches), first_err_idx 0; CNT_W = 2 build -> err_count saturates at 3.
- start pulsed during RUN -> ignored, sample_idx continues; start in DONE -> PRIME next cycle, counters cleared.
